// File: rtl/stream_sync_filter_pkg.sv
// Shared types and constants for the sensor stream sync filter.
package stream_sync_filter_pkg;

  // Frame gating states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } filt_state_t;

  localparam int unsigned DROP_CNT_W = 16;

  // Width needed to count 0..depth inclusive.
  function automatic int unsigned run_cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/stream_sync_filter_sync_delay_line.sv
// Parametric shift register with enable; output is the oldest entry.
module sync_delay_line #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one position per enabled sample; reset clears every stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else if (en) begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/stream_sync_filter.sv
// Sensor stream conditioner: delays fval/lval/data by FVAL_MIN_WIDTH samples,
// rejects frames whose fval is too short or that start while disabled, and
// counts every rejected frame.
module stream_sync_filter
  import stream_sync_filter_pkg::*;
#(
  parameter int unsigned SENSOR_DAT_WIDTH = 10,
  parameter int unsigned CHANNEL_NUM      = 4,
  parameter int unsigned FVAL_MIN_WIDTH   = 3,
  parameter string       DATA_MASK        = "TRUE"
) (
  input  logic                                 clk_pix,
  input  logic                                 reset_pix,
  input  logic                                 i_clk_en,
  input  logic                                 i_fval,
  input  logic                                 i_lval,
  input  logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] iv_pix_data,
  input  logic                                 i_stream_enable,
  output logic                                 o_clk_en,
  output logic                                 o_fval,
  output logic                                 o_lval,
  output logic [SENSOR_DAT_WIDTH*CHANNEL_NUM-1:0] ov_pix_data,
  output logic                                 o_frame_active,
  output logic [DROP_CNT_W-1:0]                ov_drop_cnt
);

  localparam int unsigned DATA_W  = SENSOR_DAT_WIDTH * CHANNEL_NUM;
  localparam int unsigned DEPTH   = FVAL_MIN_WIDTH;
  localparam int unsigned CNT_W   = run_cnt_width(FVAL_MIN_WIDTH);
  localparam bit          MASK_EN = (DATA_MASK == "TRUE");
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [DATA_W+1:0] tap;
  logic              tap_fval;
  logic              tap_lval;
  logic [DATA_W-1:0] tap_data;

  logic              in_low;
  logic              armed;
  logic [CNT_W-1:0]  run_cnt;

  filt_state_t       state;
  logic              qualify_c;
  logic              fwd_c;
  logic              drop_c;

  sync_delay_line #(
    .WIDTH (DATA_W + 2),
    .DEPTH (DEPTH)
  ) u_delay (
    .clk (clk_pix),
    .rst (reset_pix),
    .en  (i_clk_en),
    .d   ({i_fval, i_lval, iv_pix_data}),
    .q   (tap)
  );

  assign {tap_fval, tap_lval, tap_data} = tap;

  // Input fval run length since an observed rising edge; in_low starts clear
  // so a frame already in progress at reset release is never armed.
  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) begin
      in_low  <= 1'b0;
      armed   <= 1'b0;
      run_cnt <= '0;
    end else if (i_clk_en) begin
      if (!i_fval) begin
        in_low  <= 1'b1;
        armed   <= 1'b0;
        run_cnt <= '0;
      end else begin
        in_low <= 1'b0;
        if (in_low) begin
          armed   <= 1'b1;
          run_cnt <= CNT_W'(1);
        end else if (armed && (run_cnt != CNT_FULL)) begin
          run_cnt <= run_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Forward/drop decision; in IDLE a high tap fval is always a fresh rise.
  always_comb begin
    qualify_c = armed && (run_cnt == CNT_FULL) && i_stream_enable;
    fwd_c     = 1'b0;
    drop_c    = 1'b0;
    case (state)
      ST_IDLE: begin
        fwd_c  = tap_fval && qualify_c;
        drop_c = tap_fval && !qualify_c;
      end
      ST_PASS: fwd_c = tap_fval;
      default: ;
    endcase
  end

  // Frame FSM, drop counter and output register, all advancing on enabled samples.
  always_ff @(posedge clk_pix or posedge reset_pix) begin
    if (reset_pix) begin
      state          <= ST_IDLE;
      o_clk_en       <= 1'b0;
      o_fval         <= 1'b0;
      o_lval         <= 1'b0;
      ov_pix_data    <= '0;
      o_frame_active <= 1'b0;
      ov_drop_cnt    <= '0;
    end else begin
      o_clk_en <= i_clk_en;
      if (i_clk_en) begin
        case (state)
          ST_IDLE: if (tap_fval) state <= fwd_c ? ST_PASS : ST_DROP;
          default: if (!tap_fval) state <= ST_IDLE;
        endcase
        if (drop_c) ov_drop_cnt <= ov_drop_cnt + DROP_CNT_W'(1);
        o_fval         <= fwd_c;
        o_lval         <= fwd_c && tap_lval;
        o_frame_active <= fwd_c;
        ov_pix_data    <= (!MASK_EN || (fwd_c && tap_lval)) ? tap_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_sync_filter.sv
// Scoreboard bench: two filter instances (masked 4x10 D=3, unmasked 8x12 D=5)
// share randomized frame stimulus; expectations come from a frame-level model.
module tb_stream_sync_filter;

  localparam int unsigned D_A = 3;
  localparam int unsigned D_B = 5;

  logic        clk_pix;
  logic        reset_pix;
  logic        i_clk_en;
  logic        i_fval;
  logic        i_lval;
  logic        i_stream_enable;
  logic [95:0] data;

  logic        o_clk_en_a, o_fval_a, o_lval_a, o_frame_active_a;
  logic [39:0] pix_a;
  logic [15:0] drop_a;
  logic        o_clk_en_b, o_fval_b, o_lval_b, o_frame_active_b;
  logic [95:0] pix_b;
  logic [15:0] drop_b;

  initial clk_pix = 1'b0;
  always #5 clk_pix = ~clk_pix;

  stream_sync_filter #(
    .SENSOR_DAT_WIDTH (10),
    .CHANNEL_NUM      (4),
    .FVAL_MIN_WIDTH   (D_A),
    .DATA_MASK        ("TRUE")
  ) dut_a (
    .clk_pix         (clk_pix),
    .reset_pix       (reset_pix),
    .i_clk_en        (i_clk_en),
    .i_fval          (i_fval),
    .i_lval          (i_lval),
    .iv_pix_data     (data[39:0]),
    .i_stream_enable (i_stream_enable),
    .o_clk_en        (o_clk_en_a),
    .o_fval          (o_fval_a),
    .o_lval          (o_lval_a),
    .ov_pix_data     (pix_a),
    .o_frame_active  (o_frame_active_a),
    .ov_drop_cnt     (drop_a)
  );

  stream_sync_filter #(
    .SENSOR_DAT_WIDTH (12),
    .CHANNEL_NUM      (8),
    .FVAL_MIN_WIDTH   (D_B),
    .DATA_MASK        ("FALSE")
  ) dut_b (
    .clk_pix         (clk_pix),
    .reset_pix       (reset_pix),
    .i_clk_en        (i_clk_en),
    .i_fval          (i_fval),
    .i_lval          (i_lval),
    .iv_pix_data     (data),
    .i_stream_enable (i_stream_enable),
    .o_clk_en        (o_clk_en_b),
    .o_fval          (o_fval_b),
    .o_lval          (o_lval_b),
    .ov_pix_data     (pix_b),
    .o_frame_active  (o_frame_active_b),
    .ov_drop_cnt     (drop_b)
  );

  typedef struct packed {
    logic        f;
    logic        l;
    logic        a;
    logic [15:0] drop;
    logic [95:0] d;
  } exp_t;

  exp_t        q_a[$];
  exp_t        q_b[$];
  logic        hist_f[$];
  logic        hist_l[$];
  logic        hist_se[$];
  logic [95:0] hist_d[$];
  logic [15:0] drops [2];

  int   vectors     = 0;
  int   miscompares = 0;
  logic rst_hold;
  logic cur_se;
  int   en_mode;
  bit   se_jitter;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  // Frame-level reference: a frame is forwarded when its start was seen after
  // reset, fval stayed high for d samples, and enable was high when the frame
  // start reaches the output (d samples after it entered).
  task automatic predict(input int k, input int d, input bit mask, output exp_t e);
    int j, m, s;
    bit fwd, longf;
    j   = hist_f.size() - 1;
    m   = j - d;
    e   = '0;
    fwd = 1'b0;
    if (m >= 0) begin
      if (hist_f[m]) begin
        s = m;
        while (s > 0 && hist_f[s-1]) s--;
        longf = 1'b1;
        for (int i = s; i < s + d; i++) if (!hist_f[i]) longf = 1'b0;
        fwd = (s > 0) && longf && hist_se[s+d];
        if (s == m && !fwd) drops[k] = drops[k] + 16'd1;
      end
      e.f = fwd;
      e.l = fwd && hist_l[m];
      e.a = fwd;
      e.d = (!mask || e.l) ? hist_d[m] : 96'd0;
    end
    e.drop = drops[k];
  endtask

  // One clock of stimulus; enabled samples are recorded and predicted.
  task automatic drive(input bit en, input bit f, input bit l, input bit se);
    exp_t ea, eb;
    @(negedge clk_pix);
    reset_pix       = rst_hold;
    i_clk_en        = en;
    i_fval          = f;
    i_lval          = l;
    i_stream_enable = se;
    data            = {$urandom(), $urandom(), $urandom()};
    if (en && !rst_hold) begin
      hist_f.push_back(f);
      hist_l.push_back(l);
      hist_se.push_back(se);
      hist_d.push_back(data);
      predict(0, D_A, 1'b1, ea);
      predict(1, D_B, 1'b0, eb);
      q_a.push_back(ea);
      q_b.push_back(eb);
    end
  endtask

  // One enabled sample, surrounded by junk on disabled cycles per en_mode.
  task automatic sample(input bit f, input bit l);
    int gaps;
    if (se_jitter && $urandom_range(0, 7) == 0) cur_se = ~cur_se;
    gaps = (en_mode == 2) ? int'($urandom_range(0, 2)) : 0;
    repeat (gaps) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drive(1'b1, f, l, cur_se);
    if (en_mode == 1) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
  endtask

  task automatic frame(input int lines, input int llen, input int hbl);
    for (int ln = 0; ln < lines; ln++) begin
      for (int p = 0; p < llen; p++) sample(1'b1, 1'b1);
      for (int p = 0; p < hbl; p++) sample(1'b1, 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) sample(1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic clear_model();
    q_a.delete();
    q_b.delete();
    hist_f.delete();
    hist_l.delete();
    hist_se.delete();
    hist_d.delete();
    drops[0] = 16'd0;
    drops[1] = 16'd0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_ctl"}, 128'({o_clk_en_a, o_fval_a, o_lval_a, o_frame_active_a}), 128'd0);
    check({tag, "_a_data"}, 128'(pix_a), 128'd0);
    check({tag, "_a_drop"}, 128'(drop_a), 128'd0);
    check({tag, "_b_ctl"}, 128'({o_clk_en_b, o_fval_b, o_lval_b, o_frame_active_b}), 128'd0);
    check({tag, "_b_data"}, 128'(pix_b), 128'd0);
    check({tag, "_b_drop"}, 128'(drop_b), 128'd0);
  endtask

  // Monitor: pops on every output sample, and checks hold on the others.
  initial begin
    exp_t la, lb;
    la = '0;
    lb = '0;
    forever begin
      @(negedge clk_pix);
      if (reset_pix) begin
        la = '0;
        lb = '0;
      end else begin
        if (o_clk_en_a) begin
          check("a_pending", 128'(q_a.size() > 0), 128'd1);
          if (q_a.size() > 0) la = q_a.pop_front();
        end
        if (o_clk_en_b) begin
          check("b_pending", 128'(q_b.size() > 0), 128'd1);
          if (q_b.size() > 0) lb = q_b.pop_front();
        end
        check("a_fval", 128'(o_fval_a), 128'(la.f));
        check("a_lval", 128'(o_lval_a), 128'(la.l));
        check("a_active", 128'(o_frame_active_a), 128'(la.a));
        check("a_drop", 128'(drop_a), 128'(la.drop));
        check("a_data", 128'(pix_a), 128'(la.d[39:0]));
        check("b_fval", 128'(o_fval_b), 128'(lb.f));
        check("b_lval", 128'(o_lval_b), 128'(lb.l));
        check("b_active", 128'(o_frame_active_b), 128'(lb.a));
        check("b_drop", 128'(drop_b), 128'(lb.drop));
        check("b_data", 128'(pix_b), 128'(lb.d));
      end
    end
  end

  initial begin
    reset_pix       = 1'b1;
    rst_hold        = 1'b1;
    i_clk_en        = 1'b0;
    i_fval          = 1'b0;
    i_lval          = 1'b0;
    i_stream_enable = 1'b0;
    data            = '0;
    cur_se          = 1'b1;
    en_mode         = 0;
    se_jitter       = 1'b0;
    clear_model();
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b1);
    #1;
    check_all_zero("reset_state");
    rst_hold = 1'b0;

    // Long frame, continuous enable.
    idle(5);
    frame(4, 40, 10);
    idle(6);

    // Short fval pulses of 1 and 2 samples, then exactly 3.
    sample(1'b1, 1'b1); idle(3);
    frame(1, 2, 0);     idle(3);
    frame(1, 3, 0);     idle(8);

    // Half-rate enable.
    en_mode = 1;
    frame(3, 12, 4);
    idle(6);
    en_mode = 0;

    // Enable removed mid frame 5, restored mid frame 7; 1-sample fval gaps.
    frame(2, 8, 2); cur_se = 1'b0; frame(2, 8, 2); idle(1);
    frame(3, 8, 2); idle(1);
    frame(1, 8, 2); cur_se = 1'b1; frame(2, 8, 2); idle(1);
    frame(3, 8, 2); idle(8);

    // Async reset mid frame, released while fval is still high.
    frame(3, 8, 2);
    @(posedge clk_pix);
    #2;
    reset_pix = 1'b1;
    rst_hold  = 1'b1;
    clear_model();
    #1;
    check_all_zero("async_reset");
    frame(1, 6, 2);
    rst_hold = 1'b0;
    frame(3, 8, 2);
    idle(4);
    frame(2, 8, 2);
    idle(8);

    // Randomized frames, enable patterns and stream enable.
    se_jitter = 1'b1;
    for (int fr = 0; fr < 40; fr++) begin
      en_mode = int'($urandom_range(0, 2));
      if ($urandom_range(0, 3) == 0) frame(1, int'($urandom_range(1, 6)), 0);
      else frame(int'($urandom_range(1, 4)), int'($urandom_range(1, 8)), int'($urandom_range(0, 3)));
      idle(int'($urandom_range(1, 4)));
    end
    se_jitter = 1'b0;
    en_mode   = 0;
    idle(10);

    @(negedge clk_pix);
    i_clk_en = 1'b0;
    @(negedge clk_pix);
    #1;
    check("a_drained", 128'(q_a.size()), 128'd0);
    check("b_drained", 128'(q_b.size()), 128'd0);
    check("a_drop_final", 128'(drop_a), 128'(drops[0]));
    check("b_drop_final", 128'(drop_b), 128'(drops[1]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_sync_filter.md
# stream_sync_filter

Single-clock sensor stream conditioner sitting between the sensor input register and the sync buffer stage on the pixel clock. Samples fval/lval/data qualified by a clock enable, suppresses frames whose fval is shorter than a programmable minimum, and gates whole frames by stream-enable/acquisition state so only complete frames are forwarded. It generalises the existing 2x sync buffer path in channel count, data width and minimum-fval width, and adds short-frame rejection and drop counting.

## Interface
- SENSOR_DAT_WIDTH, 10, bits per channel (8–16)
- CHANNEL_NUM, 4, pixel channels per sample (1–8)
- FVAL_MIN_WIDTH, 3, minimum fval high length in enabled samples; shorter frames dropped (1–64)
- DATA_MASK, "TRUE", "TRUE" forces data to 0 when output lval low; "FALSE" passes delayed data unmodified
- clk_pix  input  1  pixel clock; single clock domain
- reset_pix  input  1  asynchronous, active-high reset
- i_clk_en  input  1  sample qualifier; all sampling/state advance only when high
- i_fval  input  1  frame valid
- i_lval  input  1  line valid
- iv_pix_data  input  SENSOR_DAT_WIDTH*CHANNEL_NUM  pixel data, channel 0 in LSBs
- i_stream_enable  input  1  se AND acq, level; sampled at frame start only
- o_clk_en  output  1  registered i_clk_en (marks output sample cycles)
- o_fval  output  1  filtered frame valid
- o_lval  output  1  filtered line valid
- ov_pix_data  output  SENSOR_DAT_WIDTH*CHANNEL_NUM  filtered data
- o_frame_active  output  1  high while state PASS
- ov_drop_cnt  output  16  count of dropped frames (short or disabled), wraps 0xFFFF→0

## Operation
- Delay line of depth D = FVAL_MIN_WIDTH holds {fval, lval, data}; shifts on i_clk_en only. Tap = oldest entry.
- Input run counter: cleared on input fval 0; on observed 0→1 of i_fval sets armed and starts at 1; increments per enabled sample while high, saturates at D. If i_fval already high at reset release, armed=0 until fval goes low: that frame is dropped.
- Frame qualifies when tap fval rises and run counter == D with armed=1 (input fval stayed high for D samples since that edge).
- FSM (advances on enabled samples): IDLE → PASS on tap fval rise, qualifies, i_stream_enable=1; IDLE → DROP on tap fval rise otherwise (increment ov_drop_cnt once); PASS/DROP → IDLE on tap fval fall.
- In PASS: o_fval=tap fval, o_lval=tap lval & tap fval, data per DATA_MASK. In IDLE/DROP: o_fval=o_lval=0, data 0 if DATA_MASK="TRUE" else tap data.
- i_stream_enable deassert mid-frame: current frame completes; next frame dropped. Deassert on same sample as tap rise: dropped.
- lval outside fval never forwarded.

## Timing
- Reset: all outputs 0, delay line cleared, run counter 0, armed 0, state IDLE, ov_drop_cnt 0.
- Latency: input sample to output = D enabled samples + 1 clk_pix (output register).
- Outputs update only on cycles following i_clk_en=1; hold otherwise. o_clk_en = i_clk_en delayed 1 clk.
- Back-to-back frames with fval low for 1 enabled sample are handled: fall returns IDLE, next rise evaluated on following sample.
- Reset asserted mid-frame: outputs drop to 0 immediately (async); in-progress input frame dropped after release (armed=0).

## Structure
- Shared include: FSM state encodings (IDLE=2'd0, PASS=2'd1, DROP=2'd2), drop counter width 16.
- One sub-module: sync_delay_line (parametric width/depth shift register with enable, async reset). Counter width = clog2(FVAL_MIN_WIDTH+1).

## Test plan
- D=3, i_clk_en=1, stream enabled, 4-line frame fval 200 samples → identical frame at output 4 clk later, ov_drop_cnt=0.
- fval pulses of 1 and 2 samples, then 3 → first two suppressed, ov_drop_cnt=2, 3-sample frame passes.
- i_clk_en toggling 1/0 (2x clock): same data as enabled-only case, outputs hold on disabled cycles, latency 2·D+1 clk.
- i_stream_enable dropped mid-frame 5, raised mid-frame 7 → frame 5 complete, 6 and 7 dropped, 8 passes; ov_drop_cnt=2.
- Reset released while i_fval high → that frame dropped, next frame passes; reset mid-frame → outputs 0 same cycle.
- CHANNEL_NUM=1/8, SENSOR_DAT_WIDTH=8/12, DATA_MASK "FALSE" → data bit-exact, lval gated by fval.
